// File: rtl/dqn_fp_pkg.sv
// Shared fp32 helpers for the DQN datapath: field positions, common
// constants and NaN/zero classification.
package dqn_fp_pkg;

    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MAN_MSB  = 22;
    localparam int FP32_MAN_LSB  = 0;

    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    // NaN: exponent all ones with a non-zero mantissa
    function automatic logic is_nan(input logic [31:0] x);
        return (&x[FP32_EXP_MSB:FP32_EXP_LSB]) && (|x[FP32_MAN_MSB:FP32_MAN_LSB]);
    endfunction

    // +0 or -0
    function automatic logic is_zero(input logic [31:0] x);
        return ~|x[FP32_EXP_MSB:0];
    endfunction

endpackage

// File: rtl/fp32_compare_gt.sv
// Combinational fp32 strict greater-than on sign-magnitude ordering.
// NaN a is never greater; any non-NaN a beats a NaN b; +0 == -0.
module fp32_compare_gt
    import dqn_fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b
);

    logic [30:0] mag_a;
    logic [30:0] mag_b;

    assign mag_a = a[FP32_EXP_MSB:0];
    assign mag_b = b[FP32_EXP_MSB:0];

    // Ordering: NaN rules first, then zero equality, then sign/magnitude
    always_comb begin
        a_gt_b = 1'b0;
        if (is_nan(a)) begin
            a_gt_b = 1'b0;
        end else if (is_nan(b)) begin
            a_gt_b = 1'b1;
        end else if (is_zero(a) && is_zero(b)) begin
            a_gt_b = 1'b0;
        end else begin
            case ({a[FP32_SIGN_BIT], b[FP32_SIGN_BIT]})
                2'b00:   a_gt_b = (mag_a > mag_b);
                2'b01:   a_gt_b = 1'b1;
                2'b10:   a_gt_b = 1'b0;
                default: a_gt_b = (mag_a < mag_b);
            endcase
        end
    end

endmodule

// File: rtl/q_argmax_select.sv
// Streaming argmax over a frame of NUM_ACTIONS fp32 Q-values. The winner is
// registered in the same cycle the last element arrives, so o_valid pulses
// one cycle later and the next frame may start without a gap.
module q_argmax_select
    import dqn_fp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ACTION_WIDTH = 2,
    parameter int NUM_ACTIONS  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_q_value,
    input  logic                    i_clear,
    output logic [ACTION_WIDTH-1:0] o_action,
    output logic [DATA_WIDTH-1:0]   o_max_q,
    output logic                    o_valid,
    output logic                    o_busy
);

    localparam logic [ACTION_WIDTH-1:0] LAST_IDX = ACTION_WIDTH'(NUM_ACTIONS - 1);
    localparam logic [ACTION_WIDTH-1:0] IDX_ONE  = ACTION_WIDTH'(1);

    logic [ACTION_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0]   best;
    logic [ACTION_WIDTH-1:0] best_idx;

    logic                    in_gt_best;
    logic                    take_new;
    logic [DATA_WIDTH-1:0]   win_q;
    logic [ACTION_WIDTH-1:0] win_idx;

    fp32_compare_gt u_cmp (
        .a      (i_q_value),
        .b      (best),
        .a_gt_b (in_gt_best)
    );

    // Element 0 always seeds the running best; later elements must strictly win
    always_comb begin
        take_new = (count == '0) || in_gt_best;
        win_q    = take_new ? i_q_value : best;
        win_idx  = take_new ? count : best_idx;
    end

    // Frame accumulation, completion and clear handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            best     <= '0;
            best_idx <= '0;
            o_action <= '0;
            o_max_q  <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                count  <= '0;
                o_busy <= 1'b0;
            end else if (i_valid) begin
                best     <= win_q;
                best_idx <= win_idx;
                if (count == LAST_IDX) begin
                    count    <= '0;
                    o_busy   <= 1'b0;
                    o_valid  <= 1'b1;
                    o_action <= win_idx;
                    o_max_q  <= win_q;
                end else begin
                    count  <= count + IDX_ONE;
                    o_busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_q_argmax_select.sv
// Directed bench for q_argmax_select with hand-computed expectations.
module tb_q_argmax_select;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_q_value;
    logic        i_clear;
    logic [1:0]  o_action;
    logic [31:0] o_max_q;
    logic        o_valid;
    logic        o_busy;

    int total = 0;
    int bad   = 0;

    q_argmax_select #(.DATA_WIDTH(32), .ACTION_WIDTH(2), .NUM_ACTIONS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_q_value (i_q_value),
        .i_clear   (i_clear),
        .o_action  (o_action),
        .o_max_q   (o_max_q),
        .o_valid   (o_valid),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: drives a gap-free frame, reports what followed it.
    // early = o_valid seen while the frame was still arriving.
    task automatic drive_frame(input logic [31:0] q0, input logic [31:0] q1,
                               input logic [31:0] q2, output logic vld,
                               output logic [1:0] act, output logic [31:0] mq,
                               output logic early);
        logic [31:0] qs [3];
        qs[0] = q0; qs[1] = q1; qs[2] = q2;
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i > 0 && o_valid) early = 1'b1;
            i_valid   = 1'b1;
            i_q_value = qs[i];
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        vld = o_valid;
        act = o_action;
        mq  = o_max_q;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_q_value = '0; i_clear = 1'b0;
        #12;
        total++; if (o_action !== 2'd0) begin bad++; $display("FAIL reset_action got=%0d want=0", o_action); end
        total++; if (o_max_q !== 32'h0) begin bad++; $display("FAIL reset_maxq got=%h want=00000000", o_max_q); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_positive();
        logic v, e; logic [1:0] a; logic [31:0] m;
        drive_frame(32'h3F800000, 32'h40000000, 32'h3F000000, v, a, m, e);
        total++; if (v !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL pos_valid got=%b early=%b want=1/0", v, e); end
        total++; if (a !== 2'd1) begin bad++; $display("FAIL pos_action got=%0d want=1", a); end
        total++; if (m !== 32'h40000000) begin bad++; $display("FAIL pos_maxq got=%h want=40000000", m); end
        @(posedge clk); #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pos_pulse_len got=%b want=0", o_valid); end
        total++; if (o_action !== 2'd1 || o_max_q !== 32'h40000000) begin bad++; $display("FAIL pos_hold got=%0d/%h want=1/40000000", o_action, o_max_q); end
    endtask

    task automatic test_negative_and_zero();
        logic v, e; logic [1:0] a; logic [31:0] m;
        drive_frame(32'hBF800000, 32'hC0000000, 32'hBF000000, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd2 || m !== 32'hBF000000) begin bad++; $display("FAIL neg got=%b/%0d/%h want=1/2/bf000000", v, a, m); end
        drive_frame(32'h80000000, 32'h00000000, 32'hBF800000, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd0 || m !== 32'h80000000) begin bad++; $display("FAIL zero_tie got=%b/%0d/%h want=1/0/80000000", v, a, m); end
    endtask

    task automatic test_ties_nan_inf();
        logic v, e; logic [1:0] a; logic [31:0] m;
        drive_frame(32'h40000000, 32'h40000000, 32'h3F800000, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd0 || m !== 32'h40000000) begin bad++; $display("FAIL tie got=%b/%0d/%h want=1/0/40000000", v, a, m); end
        drive_frame(32'h7FC00000, 32'h3F800000, 32'h7FC00001, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd1 || m !== 32'h3F800000) begin bad++; $display("FAIL nan got=%b/%0d/%h want=1/1/3f800000", v, a, m); end
        drive_frame(32'h7FC00000, 32'h7F800001, 32'hFFC00000, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd0 || m !== 32'h7FC00000) begin bad++; $display("FAIL all_nan got=%b/%0d/%h want=1/0/7fc00000", v, a, m); end
        drive_frame(32'hFF800000, 32'h7F7FFFFF, 32'h7F800000, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd2 || m !== 32'h7F800000) begin bad++; $display("FAIL inf got=%b/%0d/%h want=1/2/7f800000", v, a, m); end
        drive_frame(32'h00000001, 32'h00000002, 32'h80000005, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd1 || m !== 32'h00000002) begin bad++; $display("FAIL denorm got=%b/%0d/%h want=1/1/00000002", v, a, m); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] qs [6];
        int pulse_cyc [2];
        logic [1:0]  pa [2];
        logic [31:0] pm [2];
        int np;
        qs[0] = 32'h3F800000; qs[1] = 32'h40000000; qs[2] = 32'h3F000000;
        qs[3] = 32'h00000000; qs[4] = 32'h00000000; qs[5] = 32'h3F800000;
        np = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                if (np < 2) begin pulse_cyc[np] = c; pa[np] = o_action; pm[np] = o_max_q; end
                np++;
            end
            if (c < 6) begin i_valid = 1'b1; i_q_value = qs[c]; end
            else i_valid = 1'b0;
        end
        total++; if (np !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", np); end
        if (np >= 2) begin
            total++; if (pulse_cyc[1] - pulse_cyc[0] !== 3) begin bad++; $display("FAIL b2b_spacing got=%0d want=3", pulse_cyc[1] - pulse_cyc[0]); end
            total++; if (pa[0] !== 2'd1 || pm[0] !== 32'h40000000) begin bad++; $display("FAIL b2b_first got=%0d/%h want=1/40000000", pa[0], pm[0]); end
            total++; if (pa[1] !== 2'd2 || pm[1] !== 32'h3F800000) begin bad++; $display("FAIL b2b_second got=%0d/%h want=2/3f800000", pa[1], pm[1]); end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] qs [3];
        int np;
        logic [1:0] a; logic [31:0] m;
        qs[0] = 32'h00000000; qs[1] = 32'h00000000; qs[2] = 32'h3F800000;
        np = 0; a = 2'd0; m = '0;
        // element every third cycle: cycles 0,3,6; pulse expected at 7
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (o_valid) begin np++; a = o_action; m = o_max_q; end
            if (c == 4) begin
                total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b want=1", o_busy); end
            end
            if (c % 3 == 0 && c < 9) begin i_valid = 1'b1; i_q_value = qs[c/3]; end
            else i_valid = 1'b0;
        end
        total++; if (np !== 1 || a !== 2'd2 || m !== 32'h3F800000) begin bad++; $display("FAIL gaps got=%0d/%0d/%h want=1/2/3f800000", np, a, m); end
    endtask

    task automatic test_clear();
        int np;
        logic v, e; logic [1:0] a; logic [31:0] m;
        np = 0;
        // previous frame left o_action=2, o_max_q=3f800000
        @(posedge clk); #1; i_valid = 1'b1; i_q_value = 32'h40400000;
        @(posedge clk); #1; i_q_value = 32'h40800000;
        @(posedge clk); #1; i_q_value = 32'h7F800000; i_clear = 1'b1;
        @(posedge clk); #1; i_valid = 1'b0; i_clear = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", o_busy); end
        if (o_valid) np++;
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (o_valid) np++; end
        total++; if (np !== 0) begin bad++; $display("FAIL clear_novalid got=%0d want=0", np); end
        total++; if (o_action !== 2'd2 || o_max_q !== 32'h3F800000) begin bad++; $display("FAIL clear_hold got=%0d/%h want=2/3f800000", o_action, o_max_q); end
        drive_frame(32'h3F800000, 32'h00000000, 32'h00000000, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd0 || m !== 32'h3F800000) begin bad++; $display("FAIL after_clear got=%b/%0d/%h want=1/0/3f800000", v, a, m); end
    endtask

    task automatic test_async_reset();
        logic v, e; logic [1:0] a; logic [31:0] m;
        drive_frame(32'h3F800000, 32'h40000000, 32'h3F000000, v, a, m, e);
        @(posedge clk); #1; i_valid = 1'b1; i_q_value = 32'h7F000000;
        @(posedge clk); #1; i_valid = 1'b0;
        #2; rst_n = 1'b0; #1;
        total++; if (o_action !== 2'd0 || o_max_q !== 32'h0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%0d/%h/%b/%b want=0/0/0/0", o_action, o_max_q, o_valid, o_busy);
        end
        @(negedge clk); rst_n = 1'b1;
        drive_frame(32'h3F800000, 32'h40000000, 32'h3F000000, v, a, m, e);
        total++; if (v !== 1'b1 || a !== 2'd1 || m !== 32'h40000000) begin bad++; $display("FAIL post_reset got=%b/%0d/%h want=1/1/40000000", v, a, m); end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative_and_zero();
        test_ties_nan_inf();
        test_back_to_back();
        test_gaps();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/q_argmax_select.md
Name: q_argmax_select

Overview:
- Producer-side partner of the epsilon-greedy action selector in the DQN datapath.
- Consumes the Q-network output layer as a serial stream of NUM_ACTIONS IEEE-754 single-precision Q-values, one per valid cycle.
- Per frame, outputs the index of the largest Q-value as the predicted action, plus that maximum Q-value.
- The action drives the action-select block's predict input; the max Q feeds the target-Q computation in training.

Parameters:
- DATA_WIDTH, 32, floating-point word width; only 32 (fp32) is supported.
- ACTION_WIDTH, 2, width of the action index.
- NUM_ACTIONS, 3, Q-values per frame; legal range is 2 .. 2**ACTION_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  i_q_value is valid this cycle; consumed unconditionally, no backpressure.
- i_q_value  in  DATA_WIDTH  fp32 Q-value; its index is implicit, equal to arrival order within the frame (0 first).
- i_clear  in  1  synchronous frame abort.
- o_action  out  ACTION_WIDTH  argmax index of the completed frame.
- o_max_q  out  DATA_WIDTH  Q-value at o_action.
- o_valid  out  1  one-cycle pulse; o_action and o_max_q are valid.
- o_busy  out  1  high while a frame is partially received.

Behaviour:
- Reset values (async): o_action=0, o_max_q=0, o_valid=0, o_busy=0, element counter=0, running best=0, best index=0.
- Outputs are registered. o_action and o_max_q hold their value until the next completed frame.
- States:
  - IDLE: counter==0.
  - ACCUM: 0<counter<NUM_ACTIONS.
  - There is no separate output state. Completion happens in the same cycle the last element is accepted.
- On i_valid in IDLE: best<=i_q_value, best_idx<=0, counter<=1, go to ACCUM.
- On i_valid in ACCUM with counter=k:
  - If gt(i_q_value, best), then best<=i_q_value and best_idx<=k.
  - Counter increments.
- Last element (k==NUM_ACTIONS-1):
  - Compare as above.
  - Next cycle: o_valid=1, and o_action/o_max_q hold the final winner including the last element.
  - Counter wraps to 0 (IDLE).
- Latency: o_valid rises 1 cycle after the last element's valid cycle.
- Back-to-back frames with no gap are legal. Element 0 of the next frame may arrive in the cycle o_valid is high.
- Gaps (i_valid=0) mid-frame are legal. State holds and no timeout applies.
- i_clear has priority over i_valid. Its effect:
  - Counter<=0 and the current frame is discarded.
  - No o_valid is produced; o_action and o_max_q are unchanged.
  - A value arriving with i_clear is dropped.
- o_busy = (counter != 0), registered.
- gt(a,b) is a combinational fp32 strict greater-than using sign-magnitude ordering:
  - Positive operands: larger magnitude wins. Negative operands: smaller magnitude wins.
  - +0 and -0 compare equal.
  - ±Inf is ordered normally. Denormals are compared by bit pattern and need no normalisation.
- NaN rules (exponent all ones, mantissa != 0):
  - A NaN input is never greater than best.
  - A non-NaN input always replaces a NaN best.
  - All-NaN frame: o_action=0 and o_max_q=the element-0 NaN bits.
- Ties: strict gt, so the lowest index wins.
- Reset mid-frame: everything returns to reset values immediately, and the partial frame is lost.

Decomposition:
- Shared package dqn_fp_pkg:
  - FP32 field constants: sign bit 31, exponent [30:23], mantissa [22:0].
  - Constants FP32_ONE=32'h3F800000 and FP32_ZERO.
  - An is_nan helper.
- One sub-module fp32_compare_gt (purely combinational; inputs a, b; output a_gt_b) implementing the ordering and NaN rules above. It is reused by later max/min blocks.

Test Plan:
- Frame {3F800000 (1.0), 40000000 (2.0), 3F000000 (0.5)} -> 1 cycle after the third value, o_valid pulse, o_action=1, o_max_q=40000000.
- Frame {BF800000 (-1.0), C0000000 (-2.0), BF000000 (-0.5)} -> o_action=2, o_max_q=BF000000. Also {80000000, 00000000, BF800000} -> o_action=0 (±0 tie, lowest index).
- Ties {40000000, 40000000, 3F800000} -> o_action=0. NaN case {7FC00000, 3F800000, 7FC00001} -> o_action=1, o_max_q=3F800000.
- Two frames back-to-back with no gap, second frame {0, 0, 3F800000} -> two o_valid pulses exactly 3 cycles apart; second pulse has o_action=2. A frame with 2-cycle gaps between elements gives the same result.
- After 2 elements, assert i_clear -> o_busy=0 next cycle and no o_valid. A following full frame {3F800000, 0, 0} -> o_action=0. Assert rst_n low after 1 element -> all outputs 0 asynchronously.
